spi_xfer_arbiter: RTL

//  Shares one SPI read channel (address byte out on MOSI, data byte in on MISO) among NREQ requesters.

---
 rtl/spi_xfer_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI read channel (address out, data byte in) among NREQ requesters.
// Define SPI_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module spi_xfer_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned ASIZE    = 8,
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned CS_SETUP = 1,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic                  spi_clk,
    input  logic                  n_reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*ASIZE-1:0] addr_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [DSIZE-1:0]      rdata,
    output logic                  busy,
    output logic                  spi_cs,
    output logic                  spi_mosi_out,
    input  logic                  spi_miso_in
);

    localparam int unsigned MAX_AD   = (ASIZE > DSIZE) ? ASIZE : DSIZE;
    localparam int unsigned MAX_CS   = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int unsigned MAX_LEN  = (MAX_AD > MAX_CS) ? MAX_AD : MAX_CS;
    localparam int unsigned CW       = $clog2(MAX_LEN) + 1;
    localparam int unsigned IW       = $clog2(NREQ);
    localparam int unsigned GAP_LAST = (CS_GAP > 1) ? CS_GAP - 2 : 0;

    typedef enum logic [2:0] {StIdle, StSetup, StAddr, StData, StGap} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [DSIZE-1:0] shift_q, shift_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic [IW-1:0]    win_q, win_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [IW-1:0]    pick;
    logic             found;
    logic             active;

`ifdef SPI_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] pick_hi, pick_lo;
    logic          found_hi, found_lo;

    // Prefer the first request at or above the pointer, else wrap to the lowest one.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i] && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = IW'(i);
            end
            if (req[i] && !found_hi && (IW'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                pick_hi  = IW'(i);
            end
        end
        found = found_lo;
        pick  = found_hi ? pick_hi : pick_lo;
    end
`else
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                pick  = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        win_d   = win_q;
        done_d  = '0;
`ifdef SPI_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StSetup;
                    win_d   = pick;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (IW'(i) == pick) begin
                            addr_d = addr_in[i*ASIZE +: ASIZE];
                        end
                    end
`ifdef SPI_ARB_RR_EN
                    ptr_d = (32'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
`endif
                end
            end
            StSetup: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                addr_d = addr_q >> 1;
                if (cnt_q == CW'(ASIZE - 1)) begin
                    state_d = StData;
                end
            end
            StData: begin
                shift_d = (shift_q >> 1) | (DSIZE'(spi_miso_in) << (DSIZE - 1));
                if (cnt_q == CW'(DSIZE - 1)) begin
                    rdata_d = shift_d;
                    done_d  = NREQ'(1) << win_q;
                    // The IDLE arbitration cycle counts as the last cycle of the gap.
                    if (CS_GAP > 1) begin
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (cnt_q == CW'(GAP_LAST)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        cnt_d = ((state_q == StIdle) || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge spi_clk) begin
        if (!n_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            win_q   <= '0;
            done_q  <= '0;
`ifdef SPI_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            win_q   <= win_d;
            done_q  <= done_d;
`ifdef SPI_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign active       = (state_q == StSetup) || (state_q == StAddr) || (state_q == StData);
    assign gnt          = active ? (NREQ'(1) << win_q) : '0;
    assign spi_cs       = ~active;
    assign spi_mosi_out = (state_q == StAddr) ? addr_q[0] : 1'b0;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign rdata        = rdata_q;

endmodule
